// File: rtl/pixel_scanout_pkg.sv
// Shared types, VGA 640x480@60 timing and small helpers for the pixel scan-out reader.
package pixel_scanout_pkg;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [9:0] h_active;
        logic [9:0] h_fp;
        logic [9:0] h_sync;
        logic [9:0] h_bp;
        logic [9:0] v_active;
        logic [9:0] v_fp;
        logic [9:0] v_sync;
        logic [9:0] v_bp;
    } scan_timing_t;

    localparam int H_ACTIVE        = 640;
    localparam int H_FP            = 16;
    localparam int H_SYNC          = 96;
    localparam int H_BP            = 48;
    localparam int H_TOTAL         = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE        = 480;
    localparam int V_FP            = 10;
    localparam int V_SYNC          = 2;
    localparam int V_BP            = 33;
    localparam int V_TOTAL         = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DEF_SCALE_SHIFT = 2;
    localparam int FB_W            = H_ACTIVE >> DEF_SCALE_SHIFT;
    localparam int FB_H            = V_ACTIVE >> DEF_SCALE_SHIFT;

    localparam scan_timing_t VGA_640X480 = '{
        h_active: 10'(H_ACTIVE), h_fp: 10'(H_FP), h_sync: 10'(H_SYNC), h_bp: 10'(H_BP),
        v_active: 10'(V_ACTIVE), v_fp: 10'(V_FP), v_sync: 10'(V_SYNC), v_bp: 10'(V_BP)
    };

    // True when pos lies in [lo, lo+len-1].
    function automatic logic in_window(input logic [9:0] pos, input int lo, input int len);
        return (int'(pos) >= lo) && (int'(pos) < lo + len);
    endfunction

endpackage

// File: rtl/scan_timing_gen.sv
// Pixel-tick divider and raster counters; raw sync/active decode plus frame-start and vblank status.
module scan_timing_gen
    import pixel_scanout_pkg::*;
#(
    parameter int           CLK_DIV = 2,
    parameter scan_timing_t TIMING  = VGA_640X480
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    output logic       o_tick,
    output logic [9:0] o_h_count,
    output logic [9:0] o_v_count,
    output logic       o_active,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_frame_start,
    output logic       o_vblank
);

    localparam int H_ACT  = int'(TIMING.h_active);
    localparam int H_TOT  = H_ACT + int'(TIMING.h_fp) + int'(TIMING.h_sync) + int'(TIMING.h_bp);
    localparam int V_ACT  = int'(TIMING.v_active);
    localparam int V_TOT  = V_ACT + int'(TIMING.v_fp) + int'(TIMING.v_sync) + int'(TIMING.v_bp);
    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOT - 1);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_tick;
    logic             r_frame_start;
    logic             r_vblank;

    // Next divider and raster position; line and frame wrap land on the same tick.
    always_comb begin
        w_tick    = (r_div == DIV_LAST);
        w_div_nxt = w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
        w_h_nxt   = r_h;
        w_v_nxt   = r_v;
        if (w_tick) begin
            if (r_h == H_LAST) begin
                w_h_nxt = 10'd0;
                w_v_nxt = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
            end else begin
                w_h_nxt = r_h + 10'd1;
            end
        end else begin
            w_h_nxt = r_h;
        end
    end

    // Counter state; disable parks the raster at (0,0) so re-enable starts a fresh frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !i_enable) begin
            r_div         <= {DIV_W{1'b0}};
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b0;
        end else begin
            r_div         <= w_div_nxt;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            // Registered from next state so the pulse coincides with the (0,0) tick itself.
            r_frame_start <= (w_div_nxt == DIV_LAST) && (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
            if (w_tick) begin
                r_vblank <= (r_v >= 10'(V_ACT));
            end
        end
    end

    assign o_tick        = w_tick;
    assign o_h_count     = r_h;
    assign o_v_count     = r_v;
    assign o_active      = (r_h < 10'(H_ACT)) && (r_v < 10'(V_ACT));
    assign o_hs          = !in_window(r_h, H_ACT + int'(TIMING.h_fp), int'(TIMING.h_sync));
    assign o_vs          = !in_window(r_v, V_ACT + int'(TIMING.v_fp), int'(TIMING.v_sync));
    assign o_frame_start = r_frame_start;
    assign o_vblank      = r_vblank;

endmodule

// File: rtl/pixel_scanout_reader.sv
// Framebuffer scan-out: issues upscaled pixel-memory reads and drives VGA sync, blank and RGB332
// two pixel ticks behind the raster position.
module pixel_scanout_reader
    import pixel_scanout_pkg::*;
#(
    parameter int           N           = 32,
    parameter int           ADDR_W      = 15,
    parameter int           CLK_DIV     = 2,
    parameter int           SCALE_SHIFT = 2,
    parameter scan_timing_t TIMING      = VGA_640X480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] pixAddr,
    input  logic [N-1:0]      pixData,
    output logic              hsync,
    output logic              vsync,
    output logic              blankN,
    output rgb332_t           rgb,
    output logic              frameStart,
    output logic              vblank
);

    localparam int FB_COLS = int'(TIMING.h_active) >> SCALE_SHIFT;
    localparam int FB_ROWS = int'(TIMING.v_active) >> SCALE_SHIFT;

    generate
        if (longint'(FB_COLS) * longint'(FB_ROWS) > (longint'(1) << ADDR_W)) begin : g_addr_too_narrow
            $error("pixel_scanout_reader: framebuffer does not fit in ADDR_W address bits");
        end
        if (CLK_DIV < 2) begin : g_div_too_small
            $error("pixel_scanout_reader: CLK_DIV must be at least 2");
        end
    endgenerate

    logic              w_tick;
    logic [9:0]        w_h;
    logic [9:0]        w_v;
    logic              w_active;
    logic              w_hs;
    logic              w_vs;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused_pix_hi;

    logic [ADDR_W-1:0] r_pix_addr;
    logic              r_active1;
    logic              r_hs1;
    logic              r_vs1;
    logic              r_hsync;
    logic              r_vsync;
    logic              r_blank_n;
    rgb332_t           r_rgb;

    scan_timing_gen #(
        .CLK_DIV (CLK_DIV),
        .TIMING  (TIMING)
    ) u_timing (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_enable      (enable),
        .o_tick        (w_tick),
        .o_h_count     (w_h),
        .o_v_count     (w_v),
        .o_active      (w_active),
        .o_hs          (w_hs),
        .o_vs          (w_vs),
        .o_frame_start (frameStart),
        .o_vblank      (vblank)
    );

    assign w_addr          = ADDR_W'(((int'(w_v) >> SCALE_SHIFT) * FB_COLS) + (int'(w_h) >> SCALE_SHIFT));
    assign w_unused_pix_hi = ^pixData[N-1:8];

    // Stage 1 issues the read, stage 2 captures the returned pixel with the delayed sync/blank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pix_addr <= {ADDR_W{1'b0}};
            r_active1  <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_blank_n  <= 1'b0;
            r_rgb      <= 8'd0;
        end else if (!enable) begin
            r_active1  <= 1'b0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_blank_n  <= 1'b0;
            r_rgb      <= 8'd0;
        end else if (w_tick) begin
            r_active1  <= w_active;
            if (w_active) begin
                r_pix_addr <= w_addr;
            end
            r_hs1      <= w_hs;
            r_vs1      <= w_vs;
            r_hsync    <= r_hs1;
            r_vsync    <= r_vs1;
            r_blank_n  <= r_active1;
            r_rgb      <= r_active1 ? pixData[7:0] : 8'd0;
        end
    end

    assign pixAddr = r_pix_addr;
    assign hsync   = r_hsync;
    assign vsync   = r_vsync;
    assign blankN  = r_blank_n;
    assign rgb     = r_rgb;

endmodule

// File: tb/tb_pixel_scanout_reader.sv
// Directed bench for pixel_scanout_reader: full 800-tick lines with a shortened 19-line frame.
module tb_pixel_scanout_reader;
    import pixel_scanout_pkg::*;

    localparam int H_TOT      = 800;
    localparam int V_ACT      = 12;
    localparam int V_TOT      = 19;
    localparam int FRAME_CLKS = H_TOT * V_TOT * 2;
    localparam scan_timing_t TB_TIMING = '{
        h_active: 10'd640, h_fp: 10'd16, h_sync: 10'd96, h_bp: 10'd48,
        v_active: 10'd12,  v_fp: 10'd2,  v_sync: 10'd2,  v_bp: 10'd3
    };

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic [14:0] pixAddr;
    logic [31:0] pixData;
    logic        hsync;
    logic        vsync;
    logic        blankN;
    logic [7:0]  rgb;
    logic        frameStart;
    logic        vblank;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int hs_first, hs_line0, hs_total, vs_first, vs_total, vb_first, vb_total, fs_total;

    // clks after frameStart at which stage 1 holds a known address
    int dt_t [6] = '{1, 7, 9, 1281, 6401, 18879};
    int dt_a [6] = '{0, 0, 1, 159,  160,  479};

    pixel_scanout_reader #(
        .N(32), .ADDR_W(15), .CLK_DIV(2), .SCALE_SHIFT(2), .TIMING(TB_TIMING)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pixAddr(pixAddr), .pixData(pixData),
        .hsync(hsync), .vsync(vsync), .blankN(blankN), .rgb(rgb),
        .frameStart(frameStart), .vblank(vblank)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [14:0] a);
        return a[7:0] ^ a[14:7];
    endfunction

    function automatic int fb_addr(input int h, input int v);
        return (v >> 2) * 160 + (h >> 2);
    endfunction

    // One-clock synchronous pixel ROM.
    always @(posedge clk) pixData <= {24'd0, rom_byte(pixAddr)};

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_idle(input string tag, input int exp_addr);
        check_val({tag, "_hsync"},  int'(hsync),      1);
        check_val({tag, "_vsync"},  int'(vsync),      1);
        check_val({tag, "_blankN"}, int'(blankN),     0);
        check_val({tag, "_rgb"},    int'(rgb),        0);
        check_val({tag, "_fstart"}, int'(frameStart), 0);
        check_val({tag, "_vblank"}, int'(vblank),     0);
        check_val({tag, "_addr"},   int'(pixAddr),    exp_addr);
    endtask

    // Free-run n clks, comparing every output sample with the raster model; t counts clks since frameStart.
    task automatic run_clks(input int n);
        int p, h, v, vb_line, e_act, e_rgb, e_hs, e_vs;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            t = t + 1;
            if (t >= 3) begin
                p = (t - 3) / 2;
                h = p % H_TOT;
                v = p / H_TOT;
            end else begin
                h = H_TOT - 1;
                v = V_TOT - 1;
            end
            vb_line = ((t - 1) / 2) / H_TOT;
            e_act   = (h < 640 && v < V_ACT) ? 1 : 0;
            e_rgb   = (e_act == 1) ? int'(rom_byte(15'(fb_addr(h, v)))) : 0;
            e_hs    = (h >= 656 && h < 752) ? 0 : 1;
            e_vs    = (v >= 14 && v < 16) ? 0 : 1;
            check_val("blankN", int'(blankN), e_act);
            check_val("rgb",    int'(rgb),    e_rgb);
            check_val("hsync",  int'(hsync),  e_hs);
            check_val("vsync",  int'(vsync),  e_vs);
            check_val("vblank", int'(vblank), (vb_line >= V_ACT) ? 1 : 0);
            check_val("frameStart", int'(frameStart), (t == FRAME_CLKS) ? 1 : 0);
            for (int j = 0; j < 6; j++) begin
                if (t == dt_t[j]) check_val("pixAddr_dir", int'(pixAddr), dt_a[j]);
            end
            if (hsync == 1'b0) begin
                hs_total = hs_total + 1;
                if (t <= 1600) hs_line0 = hs_line0 + 1;
                if (hs_first < 0) hs_first = t;
            end
            if (vsync == 1'b0) begin
                vs_total = vs_total + 1;
                if (vs_first < 0) vs_first = t;
            end
            if (vblank == 1'b1) begin
                vb_total = vb_total + 1;
                if (vb_first < 0) vb_first = t;
            end
            if (frameStart == 1'b1) fs_total = fs_total + 1;
            if (t == FRAME_CLKS) t = 0;
        end
    endtask

    initial begin
        hs_first = -1; hs_line0 = 0; hs_total = 0;
        vs_first = -1; vs_total = 0;
        vb_first = -1; vb_total = 0; fs_total = 0;

        // Reset held for 5 clks
        repeat (5) @(negedge clk);
        check_idle("reset", 0);

        // Release: the (0,0) tick arrives one clk later
        rst = 1'b1;
        @(negedge clk);
        check_val("fs_after_reset", int'(frameStart), 1);
        t = 0;

        // One full frame of free running
        run_clks(FRAME_CLKS);
        check_val("hs_first_low", hs_first, 1315);
        check_val("hs_low_line0", hs_line0, 192);
        check_val("hs_low_frame", hs_total, 192 * V_TOT);
        check_val("vs_first_low", vs_first, 22403);
        check_val("vs_low_frame", vs_total, 2 * 1600);
        check_val("vb_first",     vb_first, 19201);
        check_val("vb_frame",     vb_total, 7 * 1600);
        check_val("fs_per_frame", fs_total, 1);

        // Disable at line 6, tick 300
        run_clks(10200);
        check_val("addr_line6", int'(pixAddr), 234);
        enable = 1'b0;
        @(negedge clk);
        check_idle("disable", 234);
        repeat (3) @(negedge clk);
        check_val("disable_hold_addr", int'(pixAddr), 234);
        check_val("disable_hold_fs",   int'(frameStart), 0);
        enable = 1'b1;
        @(negedge clk);
        check_val("fs_reenable", int'(frameStart), 1);
        t = 0;
        run_clks(20);

        // One-clk reset at the same raster point
        run_clks(10200 - 20);
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset", 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("fs_after_mid_reset", int'(frameStart), 1);
        t = 0;
        run_clks(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
